// File: rtl/extractor_chnl_fifo_mc.sv
// Multi-channel extractor frame FIFO: frame-granular per-channel buffering merged by frame round-robin.
// Optional macro EXTR_CHF_PEAK_LVL_EN adds the per-channel peak-level output oCHF_PEAK_WORDS.
module extractor_chnl_fifo_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DW     = 128,
    parameter int unsigned AW     = 9,
    parameter int unsigned CHW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DW-1:0]     iFMPG_CHF_DATA,
    input  logic [NUM_CH-1:0]        iFMPG_CHF_SOP,
    input  logic [NUM_CH-1:0]        iFMPG_CHF_EOP,
    input  logic [NUM_CH-1:0]        iFMPG_CHF_VALID,
    input  logic [AW:0]              iREG_AFULL_LVL,
    output logic [NUM_CH-1:0]        oCHF_AFULL,
    output logic [DW-1:0]            oDAT_DATA,
    output logic                     oDAT_SOP,
    output logic                     oDAT_EOP,
    output logic [CHW-1:0]           oDAT_CH,
    output logic                     oDAT_VALID,
    input  logic                     iDAT_READY,
    output logic [NUM_CH*32-1:0]     oINT_STATS_FRAME_DROP,
    input  logic                     iINT_STATS_LATCH_CLR,
    output logic [NUM_CH-1:0]        oCHF_DROPPING,
    output logic [NUM_CH-1:0]        oCHF_OVERFLOW,
`ifdef EXTR_CHF_PEAK_LVL_EN
    output logic [NUM_CH*(AW+1)-1:0] oCHF_PEAK_WORDS,
`endif
    output logic [NUM_CH*(AW+1)-1:0] oCHF_WORDS
);

    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] ONE       = PW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    state_t            state;
    logic [CHW-1:0]    grant;
    logic [CHW-1:0]    rr_ptr;
    logic [NUM_CH-1:0] has_frame;
    logic [DW:0]       rd_word [NUM_CH];
    logic [DW:0]       sel_word_c;
    logic              hs_c;
    logic [NUM_CH-1:0] rd_adv_c;
    logic [NUM_CH-1:0] rd_done_c;
    logic              found_c;
    logic [CHW-1:0]    pick_c;
    logic [CHW-1:0]    next_rr_c;
    int unsigned       idx_c;

    assign sel_word_c = rd_word[IW'(grant)];
    assign hs_c       = (state == XFER) & iDAT_READY;
    assign next_rr_c  = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);

    // Round-robin search from rr_ptr; the lowest offset with a committed frame wins.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx_c = 32'(rr_ptr) + 32'(i);
            if (idx_c >= NUM_CH) idx_c = idx_c - NUM_CH;
            if (has_frame[IW'(idx_c)]) begin
                found_c = 1'b1;
                pick_c  = CHW'(idx_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            oDAT_DATA  <= '0;
            oDAT_SOP   <= 1'b0;
            oDAT_EOP   <= 1'b0;
            oDAT_CH    <= '0;
            oDAT_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found_c) begin
                    grant <= pick_c;
                    state <= LOAD;
                end
                LOAD: begin
                    {oDAT_EOP, oDAT_DATA} <= sel_word_c;
                    oDAT_SOP   <= 1'b1;
                    oDAT_CH    <= grant;
                    oDAT_VALID <= 1'b1;
                    state      <= XFER;
                end
                XFER: if (iDAT_READY) begin
                    if (oDAT_EOP) begin
                        oDAT_VALID <= 1'b0;
                        oDAT_SOP   <= 1'b0;
                        oDAT_EOP   <= 1'b0;
                        rr_ptr     <= next_rr_c;
                        state      <= IDLE;
                    end else begin
                        {oDAT_EOP, oDAT_DATA} <= sel_word_c;
                        oDAT_SOP <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DW:0]    mem [DEPTH];
        logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr, frame_cnt, words_q;
        logic           in_frame, drop_st, drop_q, ovf_q, afull_q;
        logic [31:0]    drop_cnt, stats_q, cnt_inc_c;
        logic           v, s, e;
        logic [DW-1:0]  d;
        logic [PW-1:0]  lvl_c, base_c, lvl_base_c;
        logic           admit_c, drop_sop_c, wr_try_c, full_c, wr_ok_c, ovf_c, drop_word_c;
        logic           drop_st_n, in_frame_n;

        assign v = iFMPG_CHF_VALID[c];
        assign s = iFMPG_CHF_SOP[c];
        assign e = iFMPG_CHF_EOP[c];
        assign d = iFMPG_CHF_DATA[c*DW +: DW];

        // A SOP always restarts from the committed pointer, abandoning any partial frame.
        assign lvl_c       = wr_ptr - rd_ptr;
        assign base_c      = s ? commit_ptr : wr_ptr;
        assign lvl_base_c  = base_c - rd_ptr;
        assign admit_c     = v & s & (lvl_base_c < iREG_AFULL_LVL);
        assign drop_sop_c  = v & s & ~admit_c;
        assign wr_try_c    = admit_c | (v & ~s & in_frame);
        assign full_c      = (lvl_base_c == DEPTH_LVL);
        assign wr_ok_c     = wr_try_c & ~full_c;
        assign ovf_c       = wr_try_c & full_c;
        assign drop_word_c = drop_sop_c | ovf_c | (v & ~s & drop_st);
        assign cnt_inc_c   = ((drop_sop_c | ovf_c) && drop_cnt != '1) ? drop_cnt + 32'd1 : drop_cnt;

        assign has_frame[c] = (frame_cnt != '0);
        assign rd_word[c]   = mem[AW'((state == XFER) ? rd_ptr + ONE : rd_ptr)];
        assign rd_adv_c[c]  = hs_c & (grant == CHW'(c));
        assign rd_done_c[c] = rd_adv_c[c] & oDAT_EOP;

        always_comb begin
            drop_st_n  = drop_st;
            in_frame_n = in_frame;
            if (drop_sop_c | ovf_c) begin
                drop_st_n  = ~e;
                in_frame_n = 1'b0;
            end else if (wr_ok_c) begin
                drop_st_n  = 1'b0;
                in_frame_n = ~e;
            end else if (v & drop_st & e) begin
                drop_st_n  = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr     <= '0;
                commit_ptr <= '0;
                rd_ptr     <= '0;
                frame_cnt  <= '0;
                words_q    <= '0;
                in_frame   <= 1'b0;
                drop_st    <= 1'b0;
                drop_q     <= 1'b0;
                ovf_q      <= 1'b0;
                afull_q    <= 1'b0;
                drop_cnt   <= '0;
                stats_q    <= '0;
            end else begin
                in_frame <= in_frame_n;
                drop_st  <= drop_st_n;
                // Dropping output stays up through the cycle after the discarded EOP word.
                drop_q   <= drop_word_c | drop_st_n;
                if (wr_ok_c) begin
                    wr_ptr <= base_c + ONE;
                    if (e) commit_ptr <= base_c + ONE;
                end else if (drop_sop_c | ovf_c) begin
                    wr_ptr <= commit_ptr;
                end
                if (ovf_c) ovf_q <= 1'b1;
                frame_cnt <= frame_cnt + PW'(wr_ok_c & e) - PW'(rd_done_c[c]);
                if (rd_adv_c[c]) rd_ptr <= rd_ptr + ONE;
                if (iINT_STATS_LATCH_CLR) begin
                    stats_q  <= cnt_inc_c;
                    drop_cnt <= '0;
                end else begin
                    drop_cnt <= cnt_inc_c;
                end
                words_q <= commit_ptr - rd_ptr;
                afull_q <= (lvl_c >= iREG_AFULL_LVL);
            end
        end

        always_ff @(posedge clk) begin
            if (wr_ok_c) mem[AW'(base_c)] <= {e, d};
        end

        assign oCHF_AFULL[c]                   = afull_q;
        assign oCHF_DROPPING[c]                = drop_q;
        assign oCHF_OVERFLOW[c]                = ovf_q;
        assign oCHF_WORDS[c*PW +: PW]          = words_q;
        assign oINT_STATS_FRAME_DROP[c*32 +: 32] = stats_q;

`ifdef EXTR_CHF_PEAK_LVL_EN
        logic [PW-1:0] peak_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                peak_q <= '0;
            end else if (iINT_STATS_LATCH_CLR) begin
                peak_q <= lvl_c;
            end else if (lvl_c > peak_q) begin
                peak_q <= lvl_c;
            end
        end
        assign oCHF_PEAK_WORDS[c*PW +: PW] = peak_q;
`endif
    end

endmodule

// File: doc/extractor_chnl_fifo_mc.md
Name: extractor_chnl_fifo_mc

Overview:
Parametrised multi-channel successor to the extractor channel FIFO. It accepts NUM_CH independent packaged-frame streams from frame packagers and buffers each in a per-channel frame FIFO. Admission is frame-granular: a frame is either stored whole or dropped whole. The block merges complete frames onto one valid/ready output toward the time arbiter using a frame-level round-robin, and provides per-channel drop statistics and level monitoring for the register block.

Parameters:
NUM_CH, 4, number of input channels (1..8)
DW, 128, data word width
AW, 9, FIFO address width per channel; DEPTH = 2**AW words
CHW, 3, width of channel-ID output (>= clog2(NUM_CH), min 1)

Ports:
clk  in  1  core clock; sole clock
rst  in  1  synchronous reset, active-high
iFMPG_CHF_DATA  in  NUM_CH*DW  per-channel data; channel c at [c*DW +: DW]
iFMPG_CHF_SOP  in  NUM_CH  start of frame, per channel
iFMPG_CHF_EOP  in  NUM_CH  end of frame, per channel
iFMPG_CHF_VALID  in  NUM_CH  word valid, per channel; no backpressure
iREG_AFULL_LVL  in  AW+1  admission threshold, shared by all channels
oCHF_AFULL  out  NUM_CH  per channel, 1 when the write level is >= iREG_AFULL_LVL
oDAT_DATA  out  DW  merged output word
oDAT_SOP  out  1  output start of frame
oDAT_EOP  out  1  output end of frame
oDAT_CH  out  CHW  source channel of the current output word
oDAT_VALID  out  1  output word valid
iDAT_READY  in  1  consumer accepts the word when VALID and READY are both 1
oINT_STATS_FRAME_DROP  out  NUM_CH*32  latched per-channel drop counts
iINT_STATS_LATCH_CLR  in  1  latch drop counters to the output and clear them
oCHF_DROPPING  out  NUM_CH  per channel, 1 while the current input frame is being discarded
oCHF_OVERFLOW  out  NUM_CH  sticky, per channel: a frame was rolled back on full
oCHF_WORDS  out  NUM_CH*(AW+1)  committed words per channel

Behaviour:
- Reset: every pointer, counter, state register and sticky bit is cleared. Every output is 0.
  - Reset mid-frame discards all buffered and partial frames.
  - The first input after reset is honoured only on a SOP.
- Per-channel write side:
  - Pointers: wr_ptr (speculative) and commit_ptr (committed), each AW+1 bits, wrapping naturally.
  - Level = wr_ptr - rd_ptr.
- Admission decision, taken on a VALID&SOP word:
  - If level < iREG_AFULL_LVL, the frame is admitted.
  - Otherwise the frame is dropped: oCHF_DROPPING is set, and the drop counter increments once for the frame.
  - Words arriving outside a frame (VALID without a prior SOP) are ignored.
- Admitted frame:
  - Each VALID word is written to RAM together with its EOP flag.
  - On an EOP write, commit_ptr <= wr_ptr+1 and the channel's frame count increments.
  - A single-word frame (SOP and EOP together) is legal.
- Full mid-frame (level == DEPTH on a VALID write):
  - The word is not written; wr_ptr <= commit_ptr (rollback).
  - oCHF_OVERFLOW is set; the drop counter increments.
  - The remaining words of the frame are discarded as for a drop.
- Dropping state: cleared on the cycle after the VALID&EOP word. A SOP arriving while dropping restarts admission evaluation.
- Drop counters: 32 bits, saturate at 0xFFFF_FFFF.
  - On iINT_STATS_LATCH_CLR, the output is loaded with the counter value including any same-cycle increment, and the counter is cleared to 0.
- Read arbiter FSM, states IDLE, LOAD, XFER:
  - IDLE: search round-robin starting at last_grant+1 (mod NUM_CH) for a channel with frame count > 0. Grant it, go to LOAD.
  - LOAD: RAM read, latency 1 cycle. Output register filled, oDAT_VALID <= 1. Go to XFER.
  - XFER: prefetch keeps the output stream gapless while iDAT_READY is held high. On the handshake of an EOP word, the frame count is decremented, last_grant <= ch, and the FSM returns to IDLE.
  - oDAT_SOP is 1 on the first word of each granted frame.
  - Latency from the EOP write (committed) to oDAT_VALID, with the block idle: 3 cycles.
- While oDAT_VALID=1 and iDAT_READY=0: oDAT_DATA, oDAT_SOP, oDAT_EOP and oDAT_CH hold stable.
- Same-cycle write and read on one channel are both honoured. The level update is net of both.
- oCHF_WORDS = commit_ptr - rd_ptr, registered, 1-cycle delay.

Optional Feature:
EXTR_CHF_PEAK_LVL_EN
- Defined: adds output oCHF_PEAK_WORDS (NUM_CH*(AW+1)), a per-channel high-water mark of the write level.
  - Updated every cycle.
  - On iINT_STATS_LATCH_CLR, the peak is reloaded with the current level.
- Undefined: no port and no logic.

Test Plan:
- NUM_CH=4. Channels 0..3 each write one 4-word frame simultaneously, iDAT_READY=1 -> output frames in order ch0,1,2,3. Each has SOP on word 1 and EOP on word 4. First VALID 3 cycles after the EOP write.
- iREG_AFULL_LVL=8, ch1 already holds 8 words; ch1 sends a 5-word frame -> whole frame dropped, oCHF_DROPPING=1 for 5 cycles, drop count reads 1 after LATCH_CLR.
- iREG_AFULL_LVL=DEPTH, ch0 with 510 words committed; ch0 sends a 4-word frame -> rollback on the 3rd word, oCHF_OVERFLOW[0]=1, oCHF_WORDS[0] stays 510, the frame never appears on the output.
- Output backpressure: toggle iDAT_READY 1,0,0,1 during a 6-word frame -> no word lost or duplicated; outputs hold stable while READY=0.
- A drop on ch2 in the same cycle as iINT_STATS_LATCH_CLR, with prior count 7 -> output latches 8, counter becomes 0.
- Assert rst for 1 cycle mid-frame on ch3 with 2 frames queued -> all outputs 0 the next cycle; a new frame after reset is delivered intact.
